// File: rtl/mfilter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mfilter_ctrl_pkg
// Description : Shared types and constants for the match-filter controller:
//               FSM state encoding, filter parameter index bases and the
//               width of the match counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mfilter_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ARMED  = 2'd3
    } state_e;

    // Width of the filter parameter index bus
    localparam int CSTATE_W = 4;

    // Filter parameter index bases: word 1 is the length, word 2 the
    // threshold, words 3 and up are the coefficients.
    localparam logic [CSTATE_W-1:0] CSTATE_LENGTH = 4'd1;
    localparam logic [CSTATE_W-1:0] CSTATE_THRESH = 4'd2;
    localparam logic [CSTATE_W-1:0] CSTATE_COEF0  = 4'd3;

    // Width of the match counter
    localparam int COUNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mfilter_dncnt.sv
`default_nettype none
// ============================================================================
// Module      : mfilter_dncnt
// Description : Loadable down-counter that stops at zero and reports when it
//               is there. Load takes priority over decrement.
// Revision    : 1.0 - initial release
// ============================================================================
module mfilter_dncnt
    import mfilter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Load a new value, otherwise count down towards zero and hold there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/mfilter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mfilter_ctrl
// Description : Configuration and detection controller for a match filter.
//               Streams NUM_WORDS configuration words into the filter
//               parameter port, waits for the filter to settle, then counts
//               qualified matches with a holdoff window after each one.
// Revision    : 1.0 - initial release
// ============================================================================
module mfilter_ctrl
    import mfilter_ctrl_pkg::*;
#(
    parameter int NUM_WORDS     = 14,
    parameter int SETTLE_CYCLES = 8,
    parameter int TIMEOUT       = 1023,
    parameter int HOLDOFF       = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start_i,
    input  logic [31:0]         cfg_data_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    output logic [31:0]         cdata_o,
    output logic [CSTATE_W-1:0] cstate_o,
    output logic                cwrite_o,
    input  logic                filt_valid_i,
    input  logic                filt_match_i,
    output logic                armed_o,
    output logic                match_pulse_o,
    output logic [COUNT_W-1:0]  match_count_o,
    output logic                load_err_o
);

    localparam int TO_W = (TIMEOUT > 1)       ? $clog2(TIMEOUT + 1) : 1;
    localparam int HO_W = (HOLDOFF > 1)       ? $clog2(HOLDOFF + 1) : 1;
    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CSTATE_W-1:0] LAST_IDX    = CSTATE_W'(NUM_WORDS - 1);
    localparam logic [SC_W-1:0]     SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]     TO_LOAD     = TO_W'(TIMEOUT);
    localparam logic [HO_W-1:0]     HO_LOAD     = HO_W'(HOLDOFF);

    state_e               state_q;
    logic [CSTATE_W-1:0]  idx_q;
    logic [SC_W-1:0]      settle_q;
    logic [31:0]          cdata_q;
    logic [CSTATE_W-1:0]  cstate_q;
    logic                 cwrite_q;
    logic                 ready_q;
    logic                 armed_q;
    logic                 pulse_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 err_q;

    logic                 accept;
    logic                 hit;
    logic                 to_zero;
    logic                 ho_zero;

    assign accept = (state_q == ST_LOAD) && cfg_valid_i && ready_q;
    // A restart wins over a coincident match so the cleared count stays clear
    assign hit    = (state_q == ST_ARMED) && filt_valid_i && filt_match_i
                    && ho_zero && !cfg_start_i;

    // Gap timer: rearmed on every start and every accepted word
    mfilter_dncnt #(
        .WIDTH (TO_W)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cfg_start_i || accept),
        .load_val_i (TO_LOAD),
        .dec_i      (state_q == ST_LOAD),
        .zero_o     (to_zero)
    );

    // Holdoff timer: opened by a counted match, cleared by a restart
    mfilter_dncnt #(
        .WIDTH (HO_W)
    ) u_holdoff (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cfg_start_i || hit),
        .load_val_i (cfg_start_i ? '0 : HO_LOAD),
        .dec_i      (1'b1),
        .zero_o     (ho_zero)
    );

    // Controller FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            cdata_q  <= '0;
            cstate_q <= '0;
            cwrite_q <= 1'b0;
            ready_q  <= 1'b0;
            armed_q  <= 1'b0;
            pulse_q  <= 1'b0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            cwrite_q <= 1'b0;
            pulse_q  <= 1'b0;
            if (cfg_start_i) begin
                // Start from any state begins a fresh load; a word offered in
                // the same cycle is dropped without a write.
                state_q  <= ST_LOAD;
                idx_q    <= '0;
                settle_q <= '0;
                count_q  <= '0;
                err_q    <= 1'b0;
                ready_q  <= 1'b1;
                armed_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        ready_q <= 1'b0;
                    end
                    ST_LOAD: begin
                        if (accept) begin
                            cdata_q  <= cfg_data_i;
                            cstate_q <= CSTATE_LENGTH + idx_q;
                            cwrite_q <= 1'b1;
                            idx_q    <= idx_q + 1'b1;
                            if (idx_q == LAST_IDX) begin
                                state_q  <= ST_SETTLE;
                                ready_q  <= 1'b0;
                                settle_q <= '0;
                            end
                        end else if (to_zero) begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_q == SETTLE_LAST) begin
                            state_q <= ST_ARMED;
                            armed_q <= 1'b1;
                        end else begin
                            settle_q <= settle_q + 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        if (hit) begin
                            count_q <= sat_inc(count_q);
                            pulse_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_ready_o   = ready_q;
    assign cdata_o       = cdata_q;
    assign cstate_o      = cstate_q;
    assign cwrite_o      = cwrite_q;
    assign armed_o       = armed_q;
    assign match_pulse_o = pulse_q;
    assign match_count_o = count_q;
    assign load_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mfilter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mfilter_ctrl
// Description : Directed self-checking bench for mfilter_ctrl. A second
//               instance with zero holdoff exercises counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mfilter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start, cfg_valid, filt_valid, filt_match;
    logic [31:0] cfg_data;
    logic        cfg_ready, cwrite, armed, match_pulse, load_err;
    logic [31:0] cdata;
    logic [3:0]  cstate;
    logic [15:0] match_count;

    logic        s_start, s_valid, s_fv, s_fm;
    logic [31:0] s_data;
    logic        s_ready, s_cwrite, s_armed, s_pulse, s_err;
    logic [31:0] s_cdata;
    logic [3:0]  s_cstate;
    logic [15:0] s_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [3:0]  wr_cs[$];
    logic [31:0] wr_cd[$];
    int          last_wr_cyc = 0;
    int          armed_rise_cyc = -1;
    logic        armed_prev = 1'b0;

    always #5 clk = ~clk;

    mfilter_ctrl u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start_i   (cfg_start),
        .cfg_data_i    (cfg_data),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cdata_o       (cdata),
        .cstate_o      (cstate),
        .cwrite_o      (cwrite),
        .filt_valid_i  (filt_valid),
        .filt_match_i  (filt_match),
        .armed_o       (armed),
        .match_pulse_o (match_pulse),
        .match_count_o (match_count),
        .load_err_o    (load_err)
    );

    mfilter_ctrl #(.HOLDOFF(0)) u_sat (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start_i   (s_start),
        .cfg_data_i    (s_data),
        .cfg_valid_i   (s_valid),
        .cfg_ready_o   (s_ready),
        .cdata_o       (s_cdata),
        .cstate_o      (s_cstate),
        .cwrite_o      (s_cwrite),
        .filt_valid_i  (s_fv),
        .filt_match_i  (s_fm),
        .armed_o       (s_armed),
        .match_pulse_o (s_pulse),
        .match_count_o (s_count),
        .load_err_o    (s_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Write and arm monitor for the main instance
    always @(negedge clk) begin
        if (cwrite === 1'b1) begin
            wr_cs.push_back(cstate);
            wr_cd.push_back(cdata);
            last_wr_cyc = cyc;
        end
        if (armed === 1'b1 && armed_prev !== 1'b1) armed_rise_cyc = cyc;
        armed_prev = armed;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_words(input int gap, input int n);
        for (int k = 1; k <= n; k++) begin
            cfg_data  = 32'h100 + 32'(k);
            cfg_valid = 1'b1;
            tick();
            cfg_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_armed();
        for (int i = 0; i < 40; i++) begin
            if (armed === 1'b1) break;
            tick();
        end
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL arm_timeout: armed=%b required 1", armed);
        end
    endtask

    task automatic check_sequence(input string name, input int n);
        int bad;
        bad = -1;
        checks++;
        if (wr_cs.size() != n) begin
            errors++;
            $display("FAIL %s_count: writes=%0d required %0d", name, wr_cs.size(), n);
        end else begin
            for (int k = 0; k < n; k++) begin
                if (bad < 0 && (wr_cs[k] !== 4'(k + 1) || wr_cd[k] !== 32'h101 + 32'(k))) bad = k;
            end
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s_data: write %0d cstate=%0d cdata=%h required cstate=%0d cdata=%h",
                         name, bad, wr_cs[bad], wr_cd[bad], bad + 1, 32'h101 + 32'(bad));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_start = 0; cfg_valid = 0; cfg_data = '0; filt_valid = 0; filt_match = 0;
        s_start = 0; s_valid = 0; s_data = '0; s_fv = 0; s_fm = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cfg_ready, cwrite, armed, match_pulse, load_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: ready/cwrite/armed/pulse/err=%b required 00000",
                     {cfg_ready, cwrite, armed, match_pulse, load_err});
        end
        checks++;
        if (cdata !== 32'h0 || cstate !== 4'h0 || match_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: cdata=%h cstate=%h count=%h required 0", cdata, cstate, match_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_load();
        wr_cs.delete(); wr_cd.delete();
        send_start();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: cfg_ready=%b required 1", cfg_ready);
        end
        send_words(0, 14);
        checks++;
        if (cwrite !== 1'b1 || cstate !== 4'd14 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL last_word: cwrite=%b cstate=%0d ready=%b required 1/14/0", cwrite, cstate, cfg_ready);
        end
        // Results during settle must be ignored
        filt_valid = 1'b1; filt_match = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (armed === 1'b1) break;
        end
        filt_valid = 1'b0; filt_match = 1'b0;
        @(negedge clk); #1;
        check_sequence("full", 14);
        checks++;
        if (armed_rise_cyc - last_wr_cyc != 8) begin
            errors++;
            $display("FAIL settle_delay: armed after %0d cycles required 8", armed_rise_cyc - last_wr_cyc);
        end
        checks++;
        if (match_count !== 16'd0) begin
            errors++;
            $display("FAIL settle_ignore: count=%0d required 0", match_count);
        end
    endtask

    task automatic test_holdoff();
        int pulses;
        int pt[$];
        pulses = 0;
        for (int t = 0; t < 70; t++) begin
            filt_valid = (t == 0 || t == 10 || t == 64 || t == 65);
            filt_match = filt_valid;
            tick();
            if (match_pulse === 1'b1) begin
                pulses++;
                pt.push_back(t);
            end
        end
        filt_valid = 1'b0; filt_match = 1'b0;
        checks++;
        if (match_count !== 16'd2 || pulses != 2) begin
            errors++;
            $display("FAIL holdoff_count: count=%0d pulses=%0d required 2/2", match_count, pulses);
        end
        checks++;
        if (pt.size() != 2 || pt[0] != 0 || (pt[1] != 64 && pt[1] != 65)) begin
            errors++;
            $display("FAIL holdoff_timing: pulses after t=%p required t=0 and t=64 or 65", pt);
        end
        filt_match = 1'b1;
        repeat (3) tick();
        filt_match = 1'b0;
        checks++;
        if (match_count !== 16'd2) begin
            errors++;
            $display("FAIL unqualified_match: count=%0d required 2", match_count);
        end
    endtask

    task automatic test_gapped_load();
        wr_cs.delete(); wr_cd.delete();
        send_start();
        checks++;
        if (match_count !== 16'd0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: count=%0d armed=%b required 0/0", match_count, armed);
        end
        send_words(3, 14);
        wait_armed();
        @(negedge clk); #1;
        check_sequence("gapped", 14);
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("FAIL gapped_err: load_err=%b required 0", load_err);
        end
    endtask

    task automatic test_restart_reset();
        int n;
        filt_valid = 1'b1; filt_match = 1'b1;
        tick();
        filt_valid = 1'b0; filt_match = 1'b0;
        checks++;
        if (match_count !== 16'd1) begin
            errors++;
            $display("FAIL armed_match: count=%0d required 1", match_count);
        end
        repeat (70) tick();
        cfg_start = 1'b1; filt_valid = 1'b1; filt_match = 1'b1;
        tick();
        cfg_start = 1'b0; filt_valid = 1'b0; filt_match = 1'b0;
        checks++;
        if (match_count !== 16'd0 || match_pulse !== 1'b0 || armed !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_match: count=%0d pulse=%b armed=%b ready=%b required 0/0/0/1",
                     match_count, match_pulse, armed, cfg_ready);
        end
        // Start coincident with an offered word: the word is dropped
        wr_cs.delete(); wr_cd.delete();
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 32'hDEAD;
        tick();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        checks++;
        if (cwrite !== 1'b0) begin
            errors++;
            $display("FAIL start_priority: cwrite=%b required 0", cwrite);
        end
        send_words(0, 3);
        @(negedge clk); #1;
        check_sequence("partial", 3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (cwrite !== 1'b0 || cfg_ready !== 1'b0 || cstate !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: cwrite=%b ready=%b cstate=%0d required 0/0/0", cwrite, cfg_ready, cstate);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        n = wr_cs.size();
        repeat (20) tick();
        checks++;
        if (wr_cs.size() != n || match_count !== 16'd0 || armed !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: new writes=%0d count=%0d armed=%b ready=%b required 0/0/0/0",
                     wr_cs.size() - n, match_count, armed, cfg_ready);
        end
    endtask

    task automatic test_timeout();
        wr_cs.delete(); wr_cd.delete();
        send_start();
        send_words(0, 5);
        repeat (1000) tick();
        checks++;
        if (load_err !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL early_timeout: err=%b ready=%b required 0/1", load_err, cfg_ready);
        end
        repeat (40) tick();
        checks++;
        if (load_err !== 1'b1 || cfg_ready !== 1'b0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL timeout: err=%b ready=%b armed=%b required 1/0/0", load_err, cfg_ready, armed);
        end
        cfg_valid = 1'b1; cfg_data = 32'h55;
        repeat (3) tick();
        cfg_valid = 1'b0;
        @(negedge clk); #1;
        check_sequence("timeout", 5);
    endtask

    task automatic test_saturation();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            s_data = 32'h100 + 32'(k); s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (s_armed === 1'b1) break;
            tick();
        end
        checks++;
        if (s_armed !== 1'b1) begin
            errors++;
            $display("FAIL sat_arm: armed=%b required 1", s_armed);
        end
        s_fv = 1'b1; s_fm = 1'b1;
        repeat (65534) tick();
        checks++;
        if (s_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre: count=%h required fffe", s_count);
        end
        tick();
        checks++;
        if (s_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: count=%h required ffff", s_count);
        end
        repeat (4465) tick();
        s_fv = 1'b0; s_fm = 1'b0;
        checks++;
        if (s_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: count=%h required ffff", s_count);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_holdoff();
        test_gapped_load();
        test_restart_reset();
        test_timeout();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
